// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I opcodes, ALU op, control struct, immediate formats and immediate builder
package cpu_pkg;
  localparam int WORD = 32;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_size;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;
  function automatic alu_op_t alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic logic [WORD-1:0] imm_of(input logic [WORD-1:0] i, input imm_fmt_t f);
    case (f)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 2R1W register file, x0 reads zero, write-first bypass on reads
module regfile
  import cpu_pkg::*;
#(
  parameter int RF_POWER = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [RF_POWER-1:0] wa,
  input  logic [WORD-1:0]     wd,
  input  logic [RF_POWER-1:0] ra1,
  input  logic [RF_POWER-1:0] ra2,
  output logic [WORD-1:0]     rd1,
  output logic [WORD-1:0]     rd2
);
  logic [WORD-1:0] rf [0:(1<<RF_POWER)-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < (1<<RF_POWER); i++) rf[i] <= '0;
    else if (we && wa != '0) rf[wa] <= wd;
  assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : rf[ra1];
  assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : rf[ra2];
endmodule

// File: rtl/decode.sv
// decode: RV32I decode stage, owns the register file and the decode/execute register
module decode
  import cpu_pkg::*;
#(
  parameter int RF_POWER = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD-1:0]     pcPlus4,
  input  logic [WORD-1:0]     instrD,
  input  logic                stallD,
  input  logic                flushD,
  input  logic                wbEn,
  input  logic [RF_POWER-1:0] wbAddr,
  input  logic [WORD-1:0]     wbData,
  output logic [WORD-1:0]     pcE,
  output logic [WORD-1:0]     pcPlus4E,
  output logic [WORD-1:0]     rs1ValE,
  output logic [WORD-1:0]     rs2ValE,
  output logic [WORD-1:0]     immE,
  output logic [RF_POWER-1:0] rs1E,
  output logic [RF_POWER-1:0] rs2E,
  output logic [RF_POWER-1:0] rdE,
  output ctrl_t               ctrlE
);
  typedef struct packed {
    logic [WORD-1:0]     pc;
    logic [WORD-1:0]     pc4;
    logic [WORD-1:0]     rs1v;
    logic [WORD-1:0]     rs2v;
    logic [WORD-1:0]     imm;
    logic [RF_POWER-1:0] rs1;
    logic [RF_POWER-1:0] rs2;
    logic [RF_POWER-1:0] rd;
    ctrl_t               ctrl;
  } de_t;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [RF_POWER-1:0] rs1, rs2, rd;
  logic [WORD-1:0] rs1_val, rs2_val;
  ctrl_t c;
  imm_fmt_t fmt;
  de_t d, q;
  assign op  = instrD[6:0];
  assign f3  = instrD[14:12];
  assign f7  = instrD[31:25];
  assign rd  = instrD[7 +: RF_POWER];
  assign rs1 = instrD[15 +: RF_POWER];
  assign rs2 = instrD[20 +: RF_POWER];
  regfile #(.RF_POWER(RF_POWER)) u_rf (
    .clk(clk), .reset(reset), .we(wbEn), .wa(wbAddr), .wd(wbData),
    .ra1(rs1), .ra2(rs2), .rd1(rs1_val), .rd2(rs2_val)
  );
  always_comb begin
    c   = '0;
    fmt = IMM_I;
    case (op)
      OP_LUI:    begin c.alu_op = ALU_PASSB; c.alu_src_imm = 1'b1; c.reg_write = 1'b1; fmt = IMM_U; end
      OP_AUIPC:  begin c.alu_src_imm = 1'b1; c.reg_write = 1'b1; fmt = IMM_U; end
      OP_JAL:    begin c.jump = 1'b1; c.reg_write = 1'b1; fmt = IMM_J; end
      OP_JALR:   begin c.jump = 1'b1; c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.illegal = f3 != 3'd0; end
      OP_BRANCH: begin
        c.branch   = 1'b1;
        c.mem_size = f3;
        c.alu_op   = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        c.illegal  = f3[2:1] == 2'b01;
        fmt        = IMM_B;
      end
      OP_LOAD:   begin
        c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.mem_size = f3;
        c.illegal  = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OP_STORE:  begin
        c.mem_write = 1'b1; c.alu_src_imm = 1'b1; c.mem_size = f3;
        c.illegal   = f3 > 3'd2;
        fmt         = IMM_S;
      end
      OP_IMM:    begin
        c.reg_write   = 1'b1;
        c.alu_src_imm = 1'b1;
        c.alu_op      = alu_of(f3, f3 == 3'd5 && f7[5]);
        c.illegal     = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && {f7[6], f7[4:0]} != 6'd0);
      end
      OP_REG:    begin
        c.reg_write = 1'b1;
        c.alu_op    = alu_of(f3, f7[5]);
        c.illegal   = {f7[6], f7[4:0]} != 6'd0 || (f7[5] && f3 != 3'd0 && f3 != 3'd5);
      end
      default:   c.illegal = instrD != '0;
    endcase
    if (c.illegal) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    c.reg_write = c.reg_write && rd != '0;
  end
  assign d = '{
    pc: pcPlus4 - WORD'(4), pc4: pcPlus4, rs1v: rs1_val, rs2v: rs2_val,
    imm: imm_of(instrD, fmt), rs1: rs1, rs2: rs2, rd: rd, ctrl: c
  };
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (flushD) q <= '0;
    else if (!stallD) q <= d;
  assign pcE      = q.pc;
  assign pcPlus4E = q.pc4;
  assign rs1ValE  = q.rs1v;
  assign rs2ValE  = q.rs2v;
  assign immE     = q.imm;
  assign rs1E     = q.rs1;
  assign rs2E     = q.rs2;
  assign rdE      = q.rd;
  assign ctrlE    = q.ctrl;
endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard-driven self-checking bench for the decode stage
module tb_decode;
  import cpu_pkg::*;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] pcPlus4 = '0, instrD = '0, wbData = '0;
  logic        stallD = 1'b0, flushD = 1'b0, wbEn = 1'b0;
  logic [4:0]  wbAddr = '0;
  logic [31:0] pcE, pcPlus4E, rs1ValE, rs2ValE, immE;
  logic [4:0]  rs1E, rs2E, rdE;
  ctrl_t       ctrlE;
  logic [31:0] q [$];
  logic [31:0] e;
  int          checks = 0, errors = 0;
  decode #(.RF_POWER(5)) dut (
    .clk(clk), .reset(reset), .pcPlus4(pcPlus4), .instrD(instrD),
    .stallD(stallD), .flushD(flushD), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .pcE(pcE), .pcPlus4E(pcPlus4E), .rs1ValE(rs1ValE), .rs2ValE(rs2ValE), .immE(immE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .ctrlE(ctrlE)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    q.push_back(32'h0); q.push_back(32'h0);
    e = q.pop_front(); checks++;
    if (32'(ctrlE) !== e) begin errors++; $display("FAIL reset_ctrl got %h want %h", ctrlE, e); end
    e = q.pop_front(); checks++;
    if (pcPlus4E !== e) begin errors++; $display("FAIL reset_pc4 got %h want %h", pcPlus4E, e); end
    reset = 1'b0;
  endtask
  task automatic test_addi();
    wbEn = 1'b1; wbAddr = 5'd5; wbData = 32'h1234; instrD = '0;
    step();
    wbEn = 1'b0; instrD = 32'hFFF28313; pcPlus4 = 32'h8;
    q.push_back(32'h1234); q.push_back(32'hFFFF_FFFF); q.push_back(32'd6); q.push_back(32'd1); q.push_back(32'h4);
    step();
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL addi_rs1val got %h want %h", rs1ValE, e); end
    e = q.pop_front(); checks++;
    if (immE !== e) begin errors++; $display("FAIL addi_imm got %h want %h", immE, e); end
    e = q.pop_front(); checks++;
    if (32'(rdE) !== e) begin errors++; $display("FAIL addi_rd got %h want %h", rdE, e); end
    e = q.pop_front(); checks++;
    if (32'(ctrlE.reg_write) !== e) begin errors++; $display("FAIL addi_regwrite got %h want %h", ctrlE.reg_write, e); end
    e = q.pop_front(); checks++;
    if (pcE !== e) begin errors++; $display("FAIL addi_pc got %h want %h", pcE, e); end
  endtask
  task automatic test_bypass();
    wbEn = 1'b1; wbAddr = 5'd7; wbData = 32'hCAFE; instrD = 32'h00738433;
    q.push_back(32'hCAFE); q.push_back(32'hCAFE); q.push_back(32'd8); q.push_back(32'(ALU_ADD));
    step();
    wbEn = 1'b0;
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL bypass_rs1val got %h want %h", rs1ValE, e); end
    e = q.pop_front(); checks++;
    if (rs2ValE !== e) begin errors++; $display("FAIL bypass_rs2val got %h want %h", rs2ValE, e); end
    e = q.pop_front(); checks++;
    if (32'(rdE) !== e) begin errors++; $display("FAIL bypass_rd got %h want %h", rdE, e); end
    e = q.pop_front(); checks++;
    if (32'(ctrlE.alu_op) !== e) begin errors++; $display("FAIL bypass_aluop got %h want %h", ctrlE.alu_op, e); end
  endtask
  task automatic test_x0();
    wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'hFFFF; instrD = 32'h00000433;
    q.push_back(32'h0); q.push_back(32'h0);
    step();
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL x0_bypass got %h want %h", rs1ValE, e); end
    wbEn = 1'b0;
    step();
    e = q.pop_front(); checks++;
    if (rs2ValE !== e) begin errors++; $display("FAIL x0_read got %h want %h", rs2ValE, e); end
    instrD = 32'h12345037;
    q.push_back(32'h0); q.push_back(32'h1234_5000); q.push_back(32'h0);
    step();
    e = q.pop_front(); checks++;
    if (32'(ctrlE.reg_write) !== e) begin errors++; $display("FAIL lui_x0_regwrite got %h want %h", ctrlE.reg_write, e); end
    e = q.pop_front(); checks++;
    if (immE !== e) begin errors++; $display("FAIL lui_imm got %h want %h", immE, e); end
    e = q.pop_front(); checks++;
    if (32'(ctrlE.illegal) !== e) begin errors++; $display("FAIL lui_illegal got %h want %h", ctrlE.illegal, e); end
  endtask
  task automatic test_stall_flush();
    logic [31:0] seq [3];
    seq = '{32'h00738433, 32'h12345037, 32'h0000007F};
    instrD = 32'hFFF28313; pcPlus4 = 32'h20;
    step();
    stallD = 1'b1; wbEn = 1'b1; wbAddr = 5'd9; wbData = 32'h55;
    for (int i = 0; i < 3; i++) begin
      instrD = seq[i];
      q.push_back(32'h1234); q.push_back(32'hFFFF_FFFF); q.push_back(32'd6);
      step();
      e = q.pop_front(); checks++;
      if (rs1ValE !== e) begin errors++; $display("FAIL stall%0d_rs1val got %h want %h", i, rs1ValE, e); end
      e = q.pop_front(); checks++;
      if (immE !== e) begin errors++; $display("FAIL stall%0d_imm got %h want %h", i, immE, e); end
      e = q.pop_front(); checks++;
      if (32'(rdE) !== e) begin errors++; $display("FAIL stall%0d_rd got %h want %h", i, rdE, e); end
    end
    stallD = 1'b0; wbEn = 1'b0; instrD = 32'h00048533;
    q.push_back(32'h55);
    step();
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL write_during_stall got %h want %h", rs1ValE, e); end
    stallD = 1'b1; flushD = 1'b1; instrD = 32'hFFF28313;
    q.push_back(32'h0); q.push_back(32'h0);
    step();
    stallD = 1'b0; flushD = 1'b0;
    e = q.pop_front(); checks++;
    if (32'(ctrlE) !== e) begin errors++; $display("FAIL flush_ctrl got %h want %h", ctrlE, e); end
    e = q.pop_front(); checks++;
    if (32'(rdE) !== e) begin errors++; $display("FAIL flush_rd got %h want %h", rdE, e); end
  endtask
  task automatic test_branch_illegal();
    instrD = 32'hFE208CE3; pcPlus4 = 32'h104;
    q.push_back(32'hFFFF_FFF8); q.push_back(32'h100); q.push_back(32'd1); q.push_back(32'd0);
    step();
    e = q.pop_front(); checks++;
    if (immE !== e) begin errors++; $display("FAIL beq_imm got %h want %h", immE, e); end
    e = q.pop_front(); checks++;
    if (pcE !== e) begin errors++; $display("FAIL beq_pc got %h want %h", pcE, e); end
    e = q.pop_front(); checks++;
    if (32'(ctrlE.branch) !== e) begin errors++; $display("FAIL beq_branch got %h want %h", ctrlE.branch, e); end
    e = q.pop_front(); checks++;
    if (32'(ctrlE.reg_write) !== e) begin errors++; $display("FAIL beq_regwrite got %h want %h", ctrlE.reg_write, e); end
    instrD = 32'h0000007F; pcPlus4 = 32'h0;
    q.push_back(32'd1); q.push_back(32'd0); q.push_back(32'hFFFF_FFFC);
    step();
    e = q.pop_front(); checks++;
    if (32'(ctrlE.illegal) !== e) begin errors++; $display("FAIL illegal_flag got %h want %h", ctrlE.illegal, e); end
    e = q.pop_front(); checks++;
    if (32'(ctrlE.reg_write) !== e) begin errors++; $display("FAIL illegal_regwrite got %h want %h", ctrlE.reg_write, e); end
    e = q.pop_front(); checks++;
    if (pcE !== e) begin errors++; $display("FAIL pc_wrap got %h want %h", pcE, e); end
  endtask
  task automatic test_reset_midrun();
    instrD = 32'hFFF28313; pcPlus4 = 32'h40;
    step();
    #2 reset = 1'b1;
    #1;
    q.push_back(32'h0); q.push_back(32'h0);
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL async_reset_rs1val got %h want %h", rs1ValE, e); end
    e = q.pop_front(); checks++;
    if (32'(rdE) !== e) begin errors++; $display("FAIL async_reset_rd got %h want %h", rdE, e); end
    step();
    reset = 1'b0; instrD = '0;
    q.push_back(32'h0); q.push_back(32'h0);
    step();
    e = q.pop_front(); checks++;
    if (32'(ctrlE) !== e) begin errors++; $display("FAIL zero_instr_ctrl got %h want %h", ctrlE, e); end
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL zero_instr_rs1val got %h want %h", rs1ValE, e); end
    instrD = 32'h00528433;
    q.push_back(32'h0);
    step();
    e = q.pop_front(); checks++;
    if (rs1ValE !== e) begin errors++; $display("FAIL rf_cleared got %h want %h", rs1ValE, e); end
  endtask
  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_x0();
    test_stall_flush();
    test_branch_illegal();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
